// File: rtl/rom_fuse_bank_if.sv
// Request/response channel of the fuse bank: a blow request (index + key)
// and the one-cycle response strobe carrying the result code.
interface rom_fuse_bank_if #(
   parameter int IW    = 2,
   parameter int KEY_W = 32
);
   logic             req_valid;
   logic             req_ready;
   logic [IW-1:0]    req_idx;
   logic [KEY_W-1:0] req_key;
   logic             resp_valid;
   logic [1:0]       resp_code;

   modport master (
      output req_valid, req_idx, req_key,
      input  req_ready, resp_valid, resp_code
   );

   modport slave (
      input  req_valid, req_idx, req_key,
      output req_ready, resp_valid, resp_code
   );
endinterface

// File: rtl/rom_fuse_bank.sv
// Bank of one-time fuse words. Each word is blown once by a keyed request;
// wrong keys are counted and reaching the limit locks the bank into a
// terminal tamper state until reset.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | ready for a request; handshake captures index and key
// S_CHECK  | evaluate the captured request, write fuse / fail counter
// S_RESP   | register the response; go to tamper if the limit was hit
// S_TAMPER | terminal; requests drained and answered with REJECTED
module rom_fuse_bank #(
   parameter int               NUM_FUSES    = 4,
   parameter int               KEY_W        = 32,
   parameter logic [KEY_W-1:0] BLOW_KEY     = 32'hDEADDEAD,
   parameter logic [KEY_W-1:0] FUSE_VAL     = 32'hDEADBEEF,
   parameter int               MAX_ATTEMPTS = 3,
   localparam int              IW           = (NUM_FUSES > 1) ? $clog2(NUM_FUSES) : 1,
   localparam int              CW           = $clog2(MAX_ATTEMPTS + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   rom_fuse_bank_if.slave       bus,
   output logic [NUM_FUSES-1:0] locked_o,
   output logic                 tamper_o,
   output logic [CW-1:0]        fail_cnt_o
);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RESP, S_TAMPER} state_t;

   localparam logic [1:0] C_OK       = 2'b00;
   localparam logic [1:0] C_BAD_KEY  = 2'b01;
   localparam logic [1:0] C_BLOWN    = 2'b10;
   localparam logic [1:0] C_REJECTED = 2'b11;

   state_t               state_q, state_d;
   logic [KEY_W-1:0]     fuse_q [NUM_FUSES];
   logic [NUM_FUSES-1:0] locked_q, locked_d;
   logic [CW-1:0]        fail_cnt_q;
   logic [IW-1:0]        idx_q;
   logic [KEY_W-1:0]     key_q;
   logic [1:0]           code_q, check_code;
   logic                 resp_valid_q;
   logic [1:0]           resp_code_q;
   logic [1:0]           tamper_hs_q;
   logic                 req_ready;
   logic                 hs;
   logic                 sel_blown;
   logic                 at_limit;

   assign hs       = bus.req_valid & req_ready;
   assign at_limit = (fail_cnt_q == CW'(MAX_ATTEMPTS));

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state and ready decode; ready is forced low while reset is held.
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid) state_d = S_CHECK;
         end
         S_CHECK:  state_d = S_RESP;
         S_RESP:   state_d = at_limit ? S_TAMPER : S_IDLE;
         S_TAMPER: req_ready = 1'b1;
         default:  state_d = S_IDLE;
      endcase
      if (rst_i) req_ready = 1'b0;
   end

   // Classify the captured request in priority order.
   always_comb begin
      sel_blown = 1'b0;
      for (int i = 0; i < NUM_FUSES; i++)
         if (int'(idx_q) == i) sel_blown = (fuse_q[i] == FUSE_VAL);
      if (int'(idx_q) >= NUM_FUSES) check_code = C_REJECTED;
      else if (sel_blown)           check_code = C_BLOWN;
      else if (key_q == BLOW_KEY)   check_code = C_OK;
      else                          check_code = C_BAD_KEY;
   end

   // LOCKED mirrors the fuse words with one cycle of delay.
   always_comb begin
      locked_d = '0;
      for (int i = 0; i < NUM_FUSES; i++) locked_d[i] = (fuse_q[i] == FUSE_VAL);
   end

   // Fuse words and wrong-key counter; only written in CHECK, so a reset
   // arriving in CHECK wins and aborts the write.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_FUSES; i++) fuse_q[i] <= '0;
         fail_cnt_q <= '0;
         locked_q   <= '0;
         code_q     <= C_OK;
      end else begin
         locked_q <= locked_d;
         if (state_q == S_CHECK) begin
            code_q <= check_code;
            if (check_code == C_OK) begin
               for (int i = 0; i < NUM_FUSES; i++)
                  if (int'(idx_q) == i) fuse_q[i] <= FUSE_VAL;
            end else if (check_code == C_BAD_KEY && !at_limit) begin
               fail_cnt_q <= fail_cnt_q + CW'(1);
            end
         end
      end
   end

   // Request capture on an IDLE handshake.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx_q <= '0;
         key_q <= '0;
      end else if (hs && state_q == S_IDLE) begin
         idx_q <= bus.req_idx;
         key_q <= bus.req_key;
      end
   end

   // Response strobe; tamper-state handshakes ride a two-stage delay so they
   // are answered with the same latency as normal requests.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tamper_hs_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_code_q  <= C_OK;
      end else begin
         tamper_hs_q  <= {tamper_hs_q[0], hs && state_q == S_TAMPER};
         resp_valid_q <= (state_q == S_RESP) || tamper_hs_q[1];
         if (state_q == S_RESP)  resp_code_q <= code_q;
         else if (tamper_hs_q[1]) resp_code_q <= C_REJECTED;
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_code  = resp_code_q;
   assign locked_o       = locked_q;
   assign tamper_o       = (state_q == S_TAMPER);
   assign fail_cnt_o     = fail_cnt_q;

endmodule

// File: tb/tb_rom_fuse_bank.sv
module tb_rom_fuse_bank;
   localparam int          N    = 3;
   localparam int          MAXA = 3;
   localparam int          IW   = 2;
   localparam int          CW   = 2;
   localparam logic [31:0] GOOD = 32'hDEADDEAD;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  locked;
   logic          tamper;
   logic [CW-1:0] fail_cnt;

   int n_checks = 0;
   int n_err    = 0;

   bit m_blown [N];
   int m_fail;
   bit m_tamper;

   rom_fuse_bank_if #(.IW(IW), .KEY_W(32)) bus ();

   rom_fuse_bank #(.NUM_FUSES(N), .MAX_ATTEMPTS(MAXA)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .bus        (bus),
      .locked_o   (locked),
      .tamper_o   (tamper),
      .fail_cnt_o (fail_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_locked();
      logic [31:0] v = '0;
      for (int i = 0; i < N; i++) v[i] = m_blown[i];
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N; i++) m_blown[i] = 1'b0;
      m_fail   = 0;
      m_tamper = 1'b0;
   endtask

   // Result of a request as the rules define it; tamper takes effect after it.
   task automatic model_req(input int idx, input logic [31:0] key, output logic [1:0] code);
      if (m_tamper || idx >= N)  code = 2'b11;
      else if (m_blown[idx])     code = 2'b10;
      else if (key == GOOD) begin
         code = 2'b00;
         m_blown[idx] = 1'b1;
      end else begin
         code = 2'b01;
         if (m_fail < MAXA) m_fail++;
         if (m_fail == MAXA) m_tamper = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      check("rst_ready",  32'(bus.req_ready), 0);
      check("rst_rvalid", 32'(bus.resp_valid), 0);
      check("rst_code",   32'(bus.resp_code), 0);
      check("rst_locked", 32'(locked), 0);
      check("rst_tamper", 32'(tamper), 0);
      check("rst_fail",   32'(fail_cnt), 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_ready", 32'(bus.req_ready), 1);
      model_clear();
   endtask

   task automatic do_req(input int idx, input logic [31:0] key, input string tag);
      int          n = 0;
      logic [1:0]  ec;
      @(negedge clk);
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ready"}, 32'(bus.req_ready), 1);
      bus.req_valid = 1'b1;
      bus.req_idx   = IW'(idx);
      bus.req_key   = key;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_key   = $urandom;
      bus.req_idx   = IW'($urandom_range(0, 3));
      model_req(idx, key, ec);
      check({tag, "_rv_t0"}, 32'(bus.resp_valid), 0);
      @(posedge clk); #1;
      check({tag, "_rv_t1"}, 32'(bus.resp_valid), 0);
      @(posedge clk); #1;
      check({tag, "_rv_t2"}, 32'(bus.resp_valid), 1);
      check({tag, "_code"},  32'(bus.resp_code), 32'(ec));
      check({tag, "_locked"}, 32'(locked), exp_locked());
      check({tag, "_fail"},  32'(fail_cnt), 32'(m_fail));
      check({tag, "_tamper"}, 32'(tamper), 32'(m_tamper));
      @(posedge clk); #1;
      check({tag, "_rv_t3"}, 32'(bus.resp_valid), 0);
      check({tag, "_code_hold"}, 32'(bus.resp_code), 32'(ec));
   endtask

   initial begin
      int last, hs_cnt, rv_cnt;
      bus.req_valid = 1'b0;
      bus.req_idx   = '0;
      bus.req_key   = '0;
      model_clear();

      // T1 reset
      do_reset();
      check("t1_locked", 32'(locked), 0);

      // T2 blow index 2, then repeat
      do_req(2, GOOD, "t2_ok");
      check("t2_locked_val", 32'(locked), 32'b100);
      do_req(2, GOOD, "t2_again");

      // T3 three wrong keys then tamper drain
      for (int i = 0; i < 3; i++) do_req(1, 32'h12345678, "t3_bad");
      check("t3_tamper", 32'(tamper), 1);
      do_req(0, GOOD, "t3_rej");
      check("t3_locked_frozen", 32'(locked), 32'b100);

      // T4 out-of-range index
      do_reset();
      do_req(1, 32'h0BAD0BAD, "t4_pre");
      do_req(3, GOOD, "t4_oor");
      check("t4_fail_kept", 32'(fail_cnt), 1);

      // T5 reset right after a handshake aborts it
      do_reset();
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_idx   = IW'(0);
      bus.req_key   = GOOD;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check("t5_no_resp", 32'(bus.resp_valid), 0);
         check("t5_locked",  32'(locked), 0);
      end
      check("t5_idle_ready", 32'(bus.req_ready), 1);

      // T6 continuous valid: one handshake every 3 cycles, one response each
      do_reset();
      last = -1; hs_cnt = 0; rv_cnt = 0;
      bus.req_idx   = IW'(0);
      bus.req_key   = GOOD;
      for (int c = 0; c < 21; c++) begin
         @(negedge clk);
         bus.req_valid = 1'b1;
         if (bus.resp_valid) rv_cnt++;
         if (bus.req_ready) begin
            if (last >= 0) check("t6_spacing", 32'(c - last), 3);
            last = c;
            hs_cnt++;
         end
      end
      bus.req_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus.resp_valid) rv_cnt++;
      end
      check("t6_hs_cnt", 32'(hs_cnt), 7);
      check("t6_resp_cnt", 32'(rv_cnt), 32'(hs_cnt));

      // Randomized requests against the reference model
      for (int r = 0; r < 3; r++) begin
         do_reset();
         for (int k = 0; k < 12; k++) begin
            int          ridx;
            logic [31:0] rkey;
            ridx = $urandom_range(0, 3);
            rkey = ($urandom_range(0, 1) == 1) ? GOOD : 32'($urandom);
            do_req(ridx, rkey, "rnd");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
